kbmat_ps2: RTL
==============

# kbmat_ps2

PS/2 keyboard front end that builds the 64-bit Z88 key matrix `kbmat` consumed by the Blink keyboard port (IN $B2). It receives PS/2 set-2 frames, decodes make and break sequences, and holds one pressed/released bit per Z88 matrix position. The Blink row-select logic (A8–A15) reads this matrix directly.

## Interface
- `FILTER_LEN`, default 8: number of consecutive identical mck samples required to accept a `ps2_clk` level.
- `TIMEOUT`, default 16'd19660: number of mck cycles a partial frame may wait for the next clock edge (about 2 ms at 9.83 MHz).
- `mck`, input, 1: 9.83 MHz master clock. This is the only clock.
- `rin`, input, 1: reset. Asynchronous and active-high.
- `ps2_clk`, input, 1: PS/2 clock from the device. Asynchronous.
- `ps2_dat`, input, 1: PS/2 data from the device. Asynchronous.
- `kbmat`, output, 64: key matrix. Bit 8·row+col; 1 means pressed. Row r is selected by A(8+r).
- `key_valid`, output, 1: one-cycle pulse on every matrix bit change.
- `key_idx`, output, 6: matrix index of the last change.
- `key_up`, output, 1: 1 if the last change was a release.
- `err`, output, 1: one-cycle pulse on a framing, parity or timeout error.

## Operation
- Synchronisation and filtering: `ps2_clk` and `ps2_dat` each pass through a 2-FF synchroniser. `ps2_clk` is then filtered by `FILTER_LEN`. A falling edge of the filtered clock samples the synchronised `ps2_dat`.
- Frame format: start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
  - Start bit = 1: the frame is dropped silently and the receiver stays idle.
  - Bad parity or stop bit = 0: `err` pulses and the byte is discarded.
- Decoder FSM, with states IDLE, BRK, EXT, EXT_BRK, SKIP:
  - IDLE: F0 → BRK; E0 → EXT; E1 → SKIP with the skip counter loaded to 7. Any other byte is a make code for the normal table; return to IDLE.
  - EXT: F0 → EXT_BRK. Any other byte is a make code for the extended table; return to IDLE.
  - BRK: the byte is a break code for the normal table; return to IDLE.
  - EXT_BRK: the byte is a break code for the extended table; return to IDLE.
  - SKIP: discard each byte and decrement the counter; return to IDLE when it reaches 0.
- Scancode to matrix mapping (table functions in the package):
  - 5A → 6; 1C (A) → 53; 29 (Space) → 46; 12 (LShift) → 62; 59 (RShift) → 7.
  - E0 75 (Up) → 54; E0 72 (Down) → 55.
  - Unmapped codes leave `kbmat` unchanged and produce no `key_valid`.
- Matrix update rules:
  - A make code sets its bit; a break code clears its bit.
  - `key_valid` pulses only if the bit actually changes. Typematic repeats of a key already held produce no pulse.
- Special bytes:
  - AA (BAT OK) in IDLE clears all of `kbmat`. No `key_valid` pulse.
  - FA and EE are ignored.
- Any `err` returns the FSM to IDLE. Prefix state is lost and `kbmat` is untouched.

## Timing
- Reset values: `kbmat` = 0, `key_valid` = 0, `key_idx` = 0, `key_up` = 0, `err` = 0, FSM = IDLE, bit counter = 0.
- Reset asserted mid-frame aborts everything immediately. After release, reception restarts at the next start bit.
- Latency is counted from the filtered falling edge that samples the stop bit (mck cycle N):
  - The receiver asserts its internal byte strobe at N+1.
  - `kbmat`, `key_idx`, `key_up` and `key_valid` update at N+2.
  - `err` pulses at N+1.
- End-to-end input latency is 2 synchroniser cycles + `FILTER_LEN` + 2 mck cycles after the pin edge.
- A filtered clock edge arriving on the same cycle as the byte strobe is sampled normally. The receiver is ready for the next start bit at N+1.
- `kbmat` is registered and changes on at most one bit per byte. Blink may sample it on any cycle.

## Configuration
- `KBMAT_WATCHDOG_EN`, when defined:
  - A counter reloads to `TIMEOUT` on each filtered clock edge while a frame is in progress.
  - If it reaches 0, the receiver aborts the frame, pulses `err` and resets the FSM to IDLE.
- When not defined: there is no counter, and a partial frame waits indefinitely.

## Structure
- Package `kbmat_pkg` contains:
  - State enum `kbd_state_t`.
  - Constants `SC_BRK` = 8'hF0, `SC_EXT` = 8'hE0, `SC_PAUSE` = 8'hE1, `SC_BAT` = 8'hAA.
  - Mapping functions `map_norm(byte)` and `map_ext(byte)`, each returning {hit, idx[5:0]}.
- Sub-module `ps2_rx` contains the synchroniser, filter, bit shifter, parity/stop check and watchdog. Its outputs are `rx_valid`, `rx_byte` and `rx_err`.
- `kbmat_ps2` itself contains the decoder FSM and the matrix register.

## Test plan
- Send 1C, then F0 1C:
  - `kbmat[53]` = 1 with `key_valid`, `key_idx` = 53, `key_up` = 0.
  - Then `kbmat[53]` = 0 with `key_up` = 1.
- Send E0 75, then 75:
  - First sequence: bit 54 set.
  - Second byte: normal table; 75 is unmapped, so there is no change and no pulse.
- Send 12 three times, then 29:
  - Bit 62 set with exactly one `key_valid`.
  - Then bit 46 set; `kbmat` = 64'h4000_4000_0000_0000.
- Frame 1C with inverted parity → `err` pulses at N+1 and `kbmat` is unchanged. Next a valid F0 5A clears bit 6 with no stale prefix.
- Send E1 14 77 E1 F0 14 F0 77:
  - No `kbmat` change; FSM returns to IDLE.
  - A following 5A sets bit 6.
- With `KBMAT_WATCHDOG_EN` defined: stop `ps2_clk` after 4 bits for more than `TIMEOUT` cycles → `err` pulses. A following full frame 5A is decoded correctly.

Source files
------------

// File: rtl/kbmat_pkg.sv
// Shared types, scancode constants and scancode-to-matrix tables for the PS/2 keyboard front end.
package kbmat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BRK     = 3'd1,
    ST_EXT     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } kbd_state_t;

  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_BAT   = 8'hAA;

  // Bytes following E1 in the Pause sequence.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  // Returns {hit, idx[5:0]} for a code from the unprefixed table.
  function automatic logic [6:0] map_norm(input logic [7:0] code);
    case (code)
      8'h5A:   map_norm = {1'b1, 6'd6};
      8'h1C:   map_norm = {1'b1, 6'd53};
      8'h29:   map_norm = {1'b1, 6'd46};
      8'h12:   map_norm = {1'b1, 6'd62};
      8'h59:   map_norm = {1'b1, 6'd7};
      default: map_norm = 7'd0;
    endcase
  endfunction

  // Returns {hit, idx[5:0]} for a code that followed an E0 prefix.
  function automatic logic [6:0] map_ext(input logic [7:0] code);
    case (code)
      8'h75:   map_ext = {1'b1, 6'd54};
      8'h72:   map_ext = {1'b1, 6'd55};
      default: map_ext = 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: synchronisers, clock glitch filter, frame shifter and parity/stop check.
// With KBMAT_WATCHDOG_EN defined, a stalled partial frame is aborted after TIMEOUT cycles.
module ps2_rx #(
  parameter int unsigned FILTER_LEN = 8
`ifdef KBMAT_WATCHDOG_EN
  ,
  parameter logic [15:0] TIMEOUT    = 16'd19660
`endif
) (
  input  logic       mck,
  input  logic       rin,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_err
);

  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);

  logic [1:0]     clk_sync_q;
  logic [1:0]     dat_sync_q;
  logic [FCW-1:0] fcnt_q;
  logic           filt_q;
  logic [3:0]     bit_cnt_q;
  logic [7:0]     shift_q;
  logic           par_q;
  logic           flip;
  logic           fall;
  logic           wd_abort;

  always_ff @(posedge mck or posedge rin) begin
    if (rin) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
    end
  end

  // The filtered level flips once the raw level has disagreed for FILTER_LEN samples in a row.
  assign flip = (clk_sync_q[1] != filt_q) && (fcnt_q == FCW'(FILTER_LEN - 1));
  assign fall = flip && filt_q;

  always_ff @(posedge mck or posedge rin) begin
    if (rin) begin
      fcnt_q <= '0;
      filt_q <= 1'b1;
    end else if (clk_sync_q[1] == filt_q || flip) begin
      fcnt_q <= '0;
      filt_q <= clk_sync_q[1];
    end else begin
      fcnt_q <= fcnt_q + FCW'(1);
    end
  end

`ifdef KBMAT_WATCHDOG_EN
  logic [15:0] wd_q;

  always_ff @(posedge mck or posedge rin) begin
    if (rin) begin
      wd_q <= TIMEOUT;
    end else if (fall) begin
      wd_q <= TIMEOUT;
    end else if (bit_cnt_q != 4'd0 && wd_q != 16'd0) begin
      wd_q <= wd_q - 16'd1;
    end
  end

  assign wd_abort = (bit_cnt_q != 4'd0) && (wd_q == 16'd0) && !fall;
`else
  assign wd_abort = 1'b0;
`endif

  always_ff @(posedge mck or posedge rin) begin
    if (rin) begin
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'd0;
      par_q     <= 1'b0;
      rx_valid  <= 1'b0;
      rx_byte   <= 8'd0;
      rx_err    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (wd_abort) begin
        bit_cnt_q <= 4'd0;
        rx_err    <= 1'b1;
      end else if (fall) begin
        if (bit_cnt_q == 4'd0) begin
          // A high start bit is line noise; stay idle without flagging it.
          if (!dat_sync_q[1]) bit_cnt_q <= 4'd1;
        end else if (bit_cnt_q <= 4'd8) begin
          shift_q   <= {dat_sync_q[1], shift_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end else if (bit_cnt_q == 4'd9) begin
          par_q     <= dat_sync_q[1];
          bit_cnt_q <= 4'd10;
        end else begin
          bit_cnt_q <= 4'd0;
          if (dat_sync_q[1] && (^{shift_q, par_q})) begin
            rx_valid <= 1'b1;
            rx_byte  <= shift_q;
          end else begin
            rx_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/kbmat_ps2.sv
// PS/2 set-2 decoder maintaining the 64-bit Z88 key matrix read by the Blink keyboard port.
// Optional KBMAT_WATCHDOG_EN enables the partial-frame timeout in the receiver.
module kbmat_ps2
  import kbmat_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8,
  parameter logic [15:0] TIMEOUT    = 16'd19660
) (
  input  logic        mck,
  input  logic        rin,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [63:0] kbmat,
  output logic        key_valid,
  output logic [5:0]  key_idx,
  output logic        key_up,
  output logic        err
);

  if (FILTER_LEN == 0 || TIMEOUT == 16'd0) begin : g_bad_cfg
    $error("kbmat_ps2: FILTER_LEN and TIMEOUT must be non-zero");
  end

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_err;

  ps2_rx #(
    .FILTER_LEN(FILTER_LEN)
`ifdef KBMAT_WATCHDOG_EN
    ,
    .TIMEOUT   (TIMEOUT)
`endif
  ) u_rx (
    .mck     (mck),
    .rin     (rin),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .rx_valid(rx_valid),
    .rx_byte (rx_byte),
    .rx_err  (rx_err)
  );

  kbd_state_t  state_q, state_d;
  logic [2:0]  skip_q, skip_d;
  logic [63:0] mat_q, mat_d;
  logic        valid_q, valid_d;
  logic [5:0]  idx_q, idx_d;
  logic        up_q, up_d;
  logic        use_ext;
  logic        is_brk;
  logic        is_key;
  logic [6:0]  key_map;

  assign use_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
  assign is_brk  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
  assign key_map = use_ext ? map_ext(rx_byte) : map_norm(rx_byte);

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    mat_d   = mat_q;
    valid_d = 1'b0;
    idx_d   = idx_q;
    up_d    = up_q;
    is_key  = 1'b0;
    if (rx_err) begin
      state_d = ST_IDLE;
      skip_d  = 3'd0;
    end else if (rx_valid) begin
      state_d = ST_IDLE;
      case (state_q)
        ST_IDLE: begin
          // FA/EE fall through as unmapped make codes and are thus ignored.
          if (rx_byte == SC_BRK) begin
            state_d = ST_BRK;
          end else if (rx_byte == SC_EXT) begin
            state_d = ST_EXT;
          end else if (rx_byte == SC_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = PAUSE_TAIL;
          end else if (rx_byte == SC_BAT) begin
            mat_d = '0;
          end else begin
            is_key = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_byte == SC_BRK) state_d = ST_EXT_BRK;
          else is_key = 1'b1;
        end
        ST_BRK, ST_EXT_BRK: is_key = 1'b1;
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q != 3'd1) state_d = ST_SKIP;
        end
        default: state_d = ST_IDLE;
      endcase
      // Only a real bit change is reported, so typematic repeats stay silent.
      if (is_key && key_map[6] && (mat_q[key_map[5:0]] == is_brk)) begin
        mat_d[key_map[5:0]] = !is_brk;
        valid_d = 1'b1;
        idx_d   = key_map[5:0];
        up_d    = is_brk;
      end
    end
  end

  always_ff @(posedge mck or posedge rin) begin
    if (rin) begin
      state_q <= ST_IDLE;
      skip_q  <= 3'd0;
      mat_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= 6'd0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      mat_q   <= mat_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      up_q    <= up_d;
    end
  end

  assign kbmat     = mat_q;
  assign key_valid = valid_q;
  assign key_idx   = idx_q;
  assign key_up    = up_q;
  assign err       = rx_err;

endmodule
